mxrv_csr_ctrl: RTL

//  Execute-stage sequencer for Zicsr instructions; drives the read/write port of mxrv_csr_reg.

---
 rtl/mxrv_csr_ctrl_if.sv | 24 ++
 rtl/mxrv_csr_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mxrv_csr_ctrl_if.sv
// CSR file read/write port between mxrv_csr_ctrl (master) and mxrv_csr_reg (slave).
interface mxrv_csr_ctrl_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CSR_ADDR_W = 12
);
  logic [CSR_ADDR_W-1:0] csr_addr_o;
  logic                  csr_we_o;
  logic [XLEN-1:0]       csr_wdata_o;
  logic [XLEN-1:0]       csr_rdata_i;

  modport master (
    output csr_addr_o,
    output csr_we_o,
    output csr_wdata_o,
    input  csr_rdata_i
  );

  modport slave (
    input  csr_addr_o,
    input  csr_we_o,
    input  csr_wdata_o,
    output csr_rdata_i
  );
endinterface

// File: rtl/mxrv_csr_ctrl.sv
// Zicsr execute-stage sequencer: atomic read-modify-write of one CSR, old value to rd.
// Optional macro CSR_RDONLY_CHECK_EN blocks writes to the read-only CSR space and flags illegal_o.
module mxrv_csr_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CSR_ADDR_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_i,
  input  logic             inst_valid_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  output logic             ready_o,
  mxrv_csr_ctrl_if.master  csr,
  output logic [4:0]       rd_addr_o,
  output logic             rd_we_o,
  output logic [XLEN-1:0]  rd_wdata_o,
  output logic             done_o,
  output logic             illegal_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [4:0]            rd_q;
  logic [1:0]            op_q;
  logic [XLEN-1:0]       src_q;
  logic [XLEN-1:0]       old_q;
  logic                  wr_en_q;
  logic                  blocked_q;

  logic [2:0] funct3;
  logic       is_csr;
  logic       accept;
  logic       wr_en_d;

  assign funct3  = inst_i[14:12];
  assign is_csr  = (inst_i[6:0] == 7'b1110011) && (funct3[1:0] != 2'b00);
  assign accept  = inst_valid_i && (state_q == ST_IDLE) && is_csr;
  assign wr_en_d = (funct3[1:0] == 2'b01) || (inst_i[19:15] != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      src_q     <= '0;
      old_q     <= '0;
      wr_en_q   <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= inst_i[20 +: CSR_ADDR_W];
        rd_q    <= inst_i[11:7];
        op_q    <= funct3[1:0];
        src_q   <= funct3[2] ? {{(XLEN-5){1'b0}}, inst_i[19:15]} : rs1_data_i;
        wr_en_q <= wr_en_d;
`ifdef CSR_RDONLY_CHECK_EN
        blocked_q <= wr_en_d && (inst_i[31:30] == 2'b11);
`else
        blocked_q <= 1'b0;
`endif
      end
      if (state_q == ST_CAPT) begin
        old_q <= csr.csr_rdata_i;
      end
    end
  end

  // Outputs decode from state_q alone, so the async reset drops csr_we_o immediately.
  always_comb begin
    state_d         = state_q;
    ready_o         = 1'b0;
    csr.csr_addr_o  = '0;
    csr.csr_we_o    = 1'b0;
    csr.csr_wdata_o = '0;
    rd_addr_o       = '0;
    rd_we_o         = 1'b0;
    rd_wdata_o      = '0;
    done_o          = 1'b0;
    illegal_o       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (accept) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        csr.csr_addr_o = addr_q;
        state_d        = ST_CAPT;
      end
      ST_CAPT: begin
        csr.csr_addr_o = addr_q;
        state_d        = ST_WRITE;
      end
      ST_WRITE: begin
        csr.csr_addr_o = addr_q;
        csr.csr_we_o   = wr_en_q && !blocked_q;
        case (op_q)
          2'b01:   csr.csr_wdata_o = src_q;
          2'b10:   csr.csr_wdata_o = old_q | src_q;
          2'b11:   csr.csr_wdata_o = old_q & ~src_q;
          default: csr.csr_wdata_o = '0;
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        rd_addr_o  = rd_q;
        rd_wdata_o = old_q;
        rd_we_o    = (rd_q != 5'd0) && !blocked_q;
        done_o     = 1'b1;
`ifdef CSR_RDONLY_CHECK_EN
        illegal_o  = blocked_q;
`else
        illegal_o  = 1'b0;
`endif
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
